// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term generator.
// Includes a reference F(n) helper for small indices.
package fib_pkg;

    localparam int FIB_WIDTH_DEF = 20;
    localparam int FIB_IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    // Reference F(n) for n <= 30; every such term fits in 32 bits.
    function automatic logic [31:0] fib_ref(input logic [4:0] n);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
        x = 32'd0;
        y = 32'd1;
        for (int i = 0; i < 31; i++) begin
            if (i < int'(n)) begin
                t = x + y;
                x = y;
                y = t;
            end else begin
                t = x;
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/fib_core.sv
// Fibonacci datapath: holds the term pair (a, b) and their sticky overflow flags.
// load restarts the pair at (F(0), F(1)); step advances it by one term.
module fib_core
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             ovf_a
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             ovf_a_r;
    logic             ovf_b_r;
    logic [WIDTH:0]   sum_s;

    assign sum_s = {1'b0, a_r} + {1'b0, b_r};
    assign a     = a_r;
    assign ovf_a = ovf_a_r;

    // Term pair register; ovf_b runs one term ahead of ovf_a.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_r     <= '0;
            b_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_a_r <= 1'b0;
            ovf_b_r <= 1'b0;
        end else if (load) begin
            a_r     <= '0;
            b_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_a_r <= 1'b0;
            ovf_b_r <= 1'b0;
        end else if (step) begin
            a_r     <= b_r;
            b_r     <= sum_s[WIDTH-1:0];
            ovf_a_r <= ovf_b_r;
            ovf_b_r <= ovf_b_r | sum_s[WIDTH];
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            ovf_a_r <= ovf_a_r;
            ovf_b_r <= ovf_b_r;
        end
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Request/response Fibonacci term generator returning F(n) mod 2^WIDTH with overflow flag.
// Define FIB_STREAM_EN to add the term_valid/term_data stream of F(0)..F(n).
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF,
    parameter int IDX_W = FIB_IDX_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_n,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             busy
`ifdef FIB_STREAM_EN
    ,
    output logic             term_valid,
    output logic [WIDTH-1:0] term_data
`endif
);

    fib_state_e       state_r;
    logic [IDX_W-1:0] n_r;
    logic [IDX_W-1:0] cnt_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_ovf_r;
    logic [WIDTH-1:0] a_s;
    logic             ovf_a_s;
    logic             load_s;
    logic             step_s;
`ifdef FIB_STREAM_EN
    logic             term_valid_r;
    logic [WIDTH-1:0] term_data_r;
`endif

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ovf   = rsp_ovf_r;
`ifdef FIB_STREAM_EN
    assign term_valid = term_valid_r;
    assign term_data  = term_data_r;
`endif

    assign load_s = (state_r == IDLE) && req_valid && !clear;
    assign step_s = (state_r == RUN) && (cnt_r != n_r) && !clear;

    fib_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .load  (load_s),
        .step  (step_s),
        .a     (a_s),
        .ovf_a (ovf_a_s)
    );

    // Control FSM, index counter and handshake outputs; clear overrides everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            n_r          <= '0;
            cnt_r        <= '0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            rsp_data_r   <= '0;
            rsp_ovf_r    <= 1'b0;
`ifdef FIB_STREAM_EN
            term_valid_r <= 1'b0;
            term_data_r  <= '0;
`endif
        end else if (clear) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef FIB_STREAM_EN
            term_valid_r <= 1'b0;
`endif
        end else begin
`ifdef FIB_STREAM_EN
            term_valid_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        n_r         <= req_n;
                        cnt_r       <= '0;
                        state_r     <= RUN;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                RUN: begin
`ifdef FIB_STREAM_EN
                    term_valid_r <= 1'b1;
                    term_data_r  <= a_s;
`endif
                    if (cnt_r == n_r) begin
                        rsp_data_r  <= a_s;
                        rsp_ovf_r   <= ovf_a_s;
                        rsp_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed table, corner sequences and random requests.
module tb_fib_seq_gen;

    localparam int W  = 20;
    localparam int IW = 8;

    logic          clock;
    logic          reset;
    logic          clear;
    logic          req_valid;
    logic [IW-1:0] req_n;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_ovf;
    logic          busy;
`ifdef FIB_STREAM_EN
    logic          term_valid;
    logic [W-1:0]  term_data;
    logic [W-1:0]  tq[$];
`endif

    int tests = 0;
    int fails = 0;

    fib_seq_gen #(.WIDTH(W), .IDX_W(IW)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
`ifdef FIB_STREAM_EN
        ,
        .term_valid(term_valid),
        .term_data (term_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int   n;
        int   hold;
        int   exp_data;
        bit   exp_ovf;
        int   exp_lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: exact terms capped well above 2^W, plus modular terms.
    function automatic void model(input int n, output int d, output bit o);
        longint unsigned ea, eb, et;
        int unsigned ma, mb, mt;
        ea = 0; eb = 1; ma = 0; mb = 1;
        for (int k = 0; k < n; k++) begin
            mt = (ma + mb) % (32'd1 << W);
            ma = mb; mb = mt;
            et = ea + eb;
            if (et > (64'd1 << 40)) et = 64'd1 << 40;
            ea = eb; eb = et;
        end
        d = int'(ma);
        o = (ea > ((64'd1 << W) - 1));
    endfunction

    task automatic run_req(input int n, input int hold, output int d, output bit o,
                           output int lat, output int bcnt);
        bit seen;
        d = 0; o = 0; lat = 0; bcnt = 0; seen = 0;
`ifdef FIB_STREAM_EN
        tq.delete();
`endif
        @(negedge clock);
        chk("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_n     = IW'(n);
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_n     = 8'hA5;
        if (busy) bcnt++;
        while (!seen && lat < 400) begin
            @(posedge clock); #1;
            lat++;
`ifdef FIB_STREAM_EN
            if (term_valid) tq.push_back(term_data);
`endif
            if (busy) bcnt++;
            if (rsp_valid) seen = 1;
        end
        chk("rsp_timeout", seen, 1);
        d = int'(rsp_data);
        o = rsp_ovf;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, d);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("release_valid", rsp_valid, 0);
        chk("release_req_ready", req_ready, 1);
    endtask

    initial begin
        vec_t vecs[7];
        int d, lat, bc, md;
        bit o, mo;

        vecs[0] = '{5,  0, 5,      1'b0, 6};
        vecs[1] = '{0,  0, 0,      1'b0, 1};
        vecs[2] = '{1,  0, 1,      1'b0, 2};
        vecs[3] = '{30, 0, 832040, 1'b0, 31};
        vecs[4] = '{31, 0, 297693, 1'b1, 32};
        vecs[5] = '{10, 5, 55,     1'b0, 11};
        vecs[6] = '{2,  1, 1,      1'b0, 3};

        reset = 1'b0; clear = 1'b0; req_valid = 1'b0; req_n = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_ovf", rsp_ovf, 0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_req(vecs[i].n, vecs[i].hold, d, o, lat, bc);
            chk($sformatf("tbl%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("tbl%0d_ovf", i), o, vecs[i].exp_ovf);
            chk($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("tbl%0d_busy_cycles", i), bc, vecs[i].n + 1);
        end

        // clear mid-RUN: response must never appear
        @(negedge clock);
        req_valid = 1'b1; req_n = 8'd20;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        chk("clear_req_ready", req_ready, 1);
        chk("clear_busy", busy, 0);
        begin
            int rv = 0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clock); #1;
                if (rsp_valid) rv++;
            end
            chk("clear_no_rsp", rv, 0);
        end
        run_req(3, 0, d, o, lat, bc);
        chk("after_clear_data", d, 2);
        chk("after_clear_latency", lat, 4);

        // asynchronous reset mid-RUN after a nonzero result is held
        @(negedge clock);
        req_valid = 1'b1; req_n = 8'd20;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_req_ready", req_ready, 1);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_rsp_data", rsp_data, 0);
        chk("async_rst_rsp_ovf", rsp_ovf, 0);
        @(negedge clock);
        reset = 1'b1;
        run_req(7, 0, d, o, lat, bc);
        chk("after_rst_data", d, 13);
        chk("after_rst_ovf", o, 0);
`ifdef FIB_STREAM_EN
        begin
            int exp_s[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
            chk("stream_len", tq.size(), 8);
            for (int k = 0; k < 8 && k < tq.size(); k++)
                chk($sformatf("stream_term%0d", k), tq[k], exp_s[k]);
        end
`endif

        // random requests against the model
        for (int r = 0; r < 12; r++) begin
            int n, hold;
            n    = (r < 9) ? int'($urandom_range(0, 45)) : int'($urandom_range(46, 255));
            hold = int'($urandom_range(0, 3));
            model(n, md, mo);
            run_req(n, hold, d, o, lat, bc);
            chk($sformatf("rand_n%0d_data", n), d, md);
            chk($sformatf("rand_n%0d_ovf", n), o, mo);
            chk($sformatf("rand_n%0d_latency", n), lat, n + 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
